// File: rtl/cdc_pulse_hs_tx.sv
// Fast-domain transmitter of a toggle/ack pulse synchronizer: it counts incoming
// event strobes and launches them one at a time as request toggles, each waiting for the synchronized ack.
module cdc_pulse_hs_tx #(
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_f,
    input  logic             rst_n,
    input  logic             pulse_f,
    input  logic             ack_tgl_s,
    output logic             req_tgl,
    output logic             busy,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             done_f,
    output logic             overflow
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ack_sync;

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_W-1:0]       pend_q, pend_d;

    logic                   launch;
    logic                   accept;

    // Only the last synchronizer stage may feed logic; earlier stages can be metastable.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ack_tgl_s};
    end

    assign ack_sync = sync_q[SYNC_STAGES-1];

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        done_d  = 1'b0;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    launch  = 1'b1;
                    req_d   = ~req_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Exiting WAIT never launches in the same cycle; IDLE handles the next event.
                if (ack_sync == req_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A strobe at saturation is still taken when a launch frees a slot in the same cycle.
    always_comb begin
        pend_d = pend_q;
        accept = pulse_f && (launch || (pend_q != PEND_MAX));
        ovf_d  = pulse_f && !accept;
        if (accept && !launch) begin
            pend_d = pend_q + CNT_W'(1);
        end else if (!accept && launch) begin
            pend_d = pend_q - CNT_W'(1);
        end
    end

    always_comb begin
        busy_d = (state_d == WAIT);
    end

    // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk_f or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
        end
    end

    assign req_tgl  = req_q;
    assign busy     = busy_q;
    assign pend_cnt = pend_q;
    assign done_f   = done_q;
    assign overflow = ovf_q;

endmodule
